sbox_share_feeder: RTL and testbench

SBOX_SHARE_FEEDER -- requirements
Module: sbox_share_feeder

---
 rtl/sbox_share_feeder.sv | 167 ++++++++++++++++
 tb/tb_sbox_share_feeder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sbox_share_feeder.sv
// Feeds a 64-bit state nibble-by-nibble into a 3-share masked sbox stage with a
// fixed latency, collects the returned shares, recombines them into an unmasked
// result and hands it out over a valid/ready interface.
module sbox_share_feeder #(
    parameter int          LAT  = 1,
    parameter logic [32:0] SEED = 33'h1_5A5A_C3C3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_state,
    input  logic [127:0]  in_mask,
    output logic [3:0]    sb_in1,
    output logic [3:0]    sb_in2,
    output logic [3:0]    sb_in3,
    output logic [26:0]   sb_r,
    output logic [5:0]    sb_rs,
    input  logic [3:0]    sb_out1,
    input  logic [3:0]    sb_out2,
    input  logic [3:0]    sb_out3,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_state
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [32:0] LFSR_INIT = (SEED == 33'h0) ? 33'h1 : SEED;
    localparam int          DW        = $clog2(LAT + 2);

    state_e          state_q, state_d;
    logic [3:0]      issue_cnt_q;
    logic [3:0]      cap_cnt_q;
    logic [DW-1:0]   drain_cnt_q;
    logic [63:0]     data_q;
    logic [127:0]    mask_q;
    logic [32:0]     lfsr_q;
    logic [LAT-1:0]  vld_pipe_q;
    logic            cap_vld_q;
    logic [3:0]      share1_q, share2_q, share3_q;
    logic [63:0]     out_state_q;
    logic            accept;
    logic            issuing;

    assign accept    = (state_q == IDLE) && in_valid;
    assign issuing   = (state_q == ISSUE);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_state = out_state_q;
    assign sb_r      = lfsr_q[26:0];
    assign sb_rs     = lfsr_q[32:27];

    // State register; reset aborts any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: issue 16 nibbles, wait out the sbox latency plus the
    // recombination stage, then hold the result until it is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)                  state_d = ISSUE;
            ISSUE:   if (issue_cnt_q == 4'd15)      state_d = DRAIN;
            DRAIN:   if (drain_cnt_q == DW'(LAT))   state_d = DONE;
            DONE:    if (out_ready)                 state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    // Share drive: the third share is built only from registered state and mask.
    always_comb begin
        sb_in1 = 4'h0;
        sb_in2 = 4'h0;
        sb_in3 = 4'h0;
        if (issuing) begin
            sb_in1 = mask_q[{3'b000, issue_cnt_q, 2'b00} +: 4];
            sb_in2 = mask_q[{3'b001, issue_cnt_q, 2'b00} +: 4];
            sb_in3 = data_q[{issue_cnt_q, 2'b00} +: 4] ^ sb_in1 ^ sb_in2;
        end
    end

    // Input latch and issue/drain counters; issue_cnt saturates at 15 until the next block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            mask_q      <= '0;
            issue_cnt_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            if (accept) begin
                data_q      <= in_state;
                mask_q      <= in_mask;
                issue_cnt_q <= '0;
            end else if (issuing && (issue_cnt_q != 4'd15)) begin
                issue_cnt_q <= issue_cnt_q + 4'd1;
            end
            if (state_q == DRAIN) begin
                drain_cnt_q <= drain_cnt_q + 1'b1;
            end else begin
                drain_cnt_q <= '0;
            end
        end
    end

    // Randomness LFSR, x^33 + x^13 + 1 Fibonacci form, stepping once per issued nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_INIT;
        end else if (issuing) begin
            lfsr_q <= {lfsr_q[31:0], lfsr_q[32] ^ lfsr_q[12]};
        end
    end

    // Tracks which cycles carry valid sbox output, LAT cycles behind issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= issuing;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            end
        end
    end

    // Shares are registered separately so no share combination happens on the sbox output wires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            share1_q  <= '0;
            share2_q  <= '0;
            share3_q  <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            cap_vld_q <= vld_pipe_q[LAT-1];
            if (vld_pipe_q[LAT-1]) begin
                share1_q <= sb_out1;
                share2_q <= sb_out2;
                share3_q <= sb_out3;
            end
        end
    end

    // Recombine the registered shares into the result nibble selected by cap_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state_q <= '0;
            cap_cnt_q   <= '0;
        end else begin
            if (accept) begin
                cap_cnt_q <= '0;
            end else if (cap_vld_q) begin
                out_state_q[{cap_cnt_q, 2'b00} +: 4] <= share1_q ^ share2_q ^ share3_q;
                if (cap_cnt_q != 4'd15) begin
                    cap_cnt_q <= cap_cnt_q + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sbox_share_feeder.sv
// Directed bench for sbox_share_feeder with a behavioural masked-sbox stub.
module tb_sbox_share_feeder;

    localparam int          LAT  = 1;
    localparam logic [32:0] SEED = 33'h1_5A5A_C3C3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   in_state = '0;
    logic [127:0]  in_mask = '0;
    logic [3:0]    sb_in1, sb_in2, sb_in3;
    logic [26:0]   sb_r;
    logic [5:0]    sb_rs;
    logic [3:0]    sb_out1, sb_out2, sb_out3;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_state;

    int            testsRun = 0;
    int            testsFailed = 0;
    int            sboxMode = 0;
    logic [32:0]   expLfsr;
    logic [11:0]   stubPipe [LAT];

    sbox_share_feeder #(.LAT(LAT), .SEED(SEED)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_mask   (in_mask),
        .sb_in1    (sb_in1),
        .sb_in2    (sb_in2),
        .sb_in3    (sb_in3),
        .sb_r      (sb_r),
        .sb_rs     (sb_rs),
        .sb_out1   (sb_out1),
        .sb_out2   (sb_out2),
        .sb_out3   (sb_out3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] sb0(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'hA;  4'h2: return 4'hD;  4'h3: return 4'h3;
            4'h4: return 4'hE;  4'h5: return 4'hB;  4'h6: return 4'hF;  4'h7: return 4'h7;
            4'h8: return 4'h8;  4'h9: return 4'h9;  4'hA: return 4'h1;  4'hB: return 4'h5;
            4'hC: return 4'h0;  4'hD: return 4'h2;  4'hE: return 4'h4;  default: return 4'h6;
        endcase
    endfunction

    // Mode 0 passes shares through; mode 1 returns a valid sharing of Sb0(x).
    function automatic logic [11:0] stubF(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        if (sboxMode == 0) return {a, b, c};
        return {a, b, sb0(a ^ b ^ c) ^ a ^ b};
    endfunction

    // Sbox stub with LAT cycles of latency.
    always @(posedge clk) begin
        stubPipe[0] <= stubF(sb_in1, sb_in2, sb_in3);
        for (int i = 1; i < LAT; i++) stubPipe[i] <= stubPipe[i-1];
    end
    assign {sb_out1, sb_out2, sb_out3} = stubPipe[LAT-1];

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic advanceModel();
        expLfsr = {expLfsr[31:0], expLfsr[32] ^ expLfsr[12]};
    endtask

    // Runs one block; abortAt >= 0 pulses reset during that ISSUE cycle instead of finishing.
    task automatic applyStimulus(input string tag, input logic [63:0] st, input logic [127:0] mk,
                                 input int mode, input logic [63:0] expOut, input int holdCycles,
                                 input bit busyPulse, input int abortAt);
        int          cnt;
        int          k;
        logic [32:0] prevRnd;
        logic [32:0] frozen;
        sboxMode = mode;
        prevRnd  = '0;
        frozen   = '0;
        checkOutput({tag, "_in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1;
        in_state = st;
        in_mask  = mk;
        stepCycle();
        in_valid = 1'b0;
        in_state = ~st;
        in_mask  = ~mk;
        cnt = 1;
        while (!out_valid && cnt <= 60) begin
            if (abortAt >= 0 && cnt == abortAt + 1) begin
                rst_n = 1'b0;
                #1;
                checkOutput({tag, "_rst_outs"}, {out_valid, out_state, sb_in1, sb_in2, sb_in3}, '0);
                checkOutput({tag, "_rst_in_ready"}, in_ready, 1);
                checkOutput({tag, "_rst_sb_r"}, sb_r, SEED[26:0]);
                #1;
                rst_n = 1'b1;
                expLfsr = SEED;
                stepCycle();
                checkOutput({tag, "_in_ready_after_rst"}, in_ready, 1);
                return;
            end
            if (cnt <= 16) begin
                k = cnt - 1;
                checkOutput({tag, "_sb_in1"}, sb_in1, mk[4*k +: 4]);
                checkOutput({tag, "_sb_in2"}, sb_in2, mk[64+4*k +: 4]);
                checkOutput({tag, "_sb_in3"}, sb_in3, st[4*k +: 4] ^ mk[4*k +: 4] ^ mk[64+4*k +: 4]);
                checkOutput({tag, "_sb_rnd"}, {sb_rs, sb_r}, expLfsr);
                if (cnt > 1) checkOutput({tag, "_rnd_changes"}, ({sb_rs, sb_r} != prevRnd), 1);
                prevRnd = {sb_rs, sb_r};
                advanceModel();
                if (busyPulse && cnt == 4) begin
                    in_valid = 1'b1;
                    in_state = 64'hDEAD_BEEF_DEAD_BEEF;
                    checkOutput({tag, "_in_ready_busy"}, in_ready, 0);
                end
                if (busyPulse && cnt == 5) in_valid = 1'b0;
            end else begin
                checkOutput({tag, "_sb_in_idle"}, {sb_in1, sb_in2, sb_in3}, 0);
                if (cnt == 17) frozen = {sb_rs, sb_r};
                else checkOutput({tag, "_rnd_frozen"}, {sb_rs, sb_r}, frozen);
            end
            stepCycle();
            cnt++;
        end
        checkOutput({tag, "_latency"}, cnt, 18 + LAT);
        if (!out_valid) return;
        checkOutput({tag, "_out_state"}, out_state, expOut);
        checkOutput({tag, "_rnd_frozen_done"}, {sb_rs, sb_r}, frozen);
        for (int h = 0; h < holdCycles; h++) begin
            stepCycle();
            checkOutput({tag, "_hold"}, {out_valid, in_ready, out_state}, {1'b1, 1'b0, expOut});
        end
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;
        checkOutput({tag, "_after_hs"}, {out_valid, in_ready}, 2'b01);
    endtask

    // Directed sequence: reset, identity and Sb0 blocks, back-pressure, busy pulse, abort.
    initial begin
        expLfsr = SEED;
        #12;
        checkOutput("reset_outs", {out_valid, out_state, sb_in1, sb_in2, sb_in3}, '0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_sb_r", sb_r, SEED[26:0]);
        #11;
        rst_n = 1'b1;
        stepCycle();
        checkOutput("first_cycle_in_ready", in_ready, 1);

        applyStimulus("ident_rand", 64'h0123_4567_89AB_CDEF,
                      128'h3C5A_9E17_B2D4_6F08_A1C3_E5F7_0921_4B6D, 0,
                      64'h0123_4567_89AB_CDEF, 0, 1'b0, -1);
        applyStimulus("ident_zero", 64'h0123_4567_89AB_CDEF, 128'h0, 0,
                      64'h0123_4567_89AB_CDEF, 0, 1'b0, -1);
        applyStimulus("sb0_zero", 64'h0, 128'h7E21_94AC_0F3B_D856_C4A9_1E7B_30F2_658D, 1,
                      64'hCCCC_CCCC_CCCC_CCCC, 10, 1'b0, -1);
        applyStimulus("sb0_ones", 64'hFFFF_FFFF_FFFF_FFFF,
                      128'h1357_9BDF_2468_ACE0_FEDC_BA98_7654_3210, 1,
                      64'h6666_6666_6666_6666, 2, 1'b1, -1);
        applyStimulus("sb0_ramp", 64'h0123_4567_89AB_CDEF, 128'h0, 1,
                      64'hCAD3_EBF7_8915_0246, 0, 1'b0, -1);
        applyStimulus("abort", 64'hA5A5_A5A5_A5A5_A5A5,
                      128'h0F0F_0F0F_0F0F_0F0F_F0F0_F0F0_F0F0_F0F0, 1,
                      64'h0, 0, 1'b0, 7);
        applyStimulus("post_abort", 64'hFEDC_BA98_7654_3210,
                      128'h5555_AAAA_3333_CCCC_9999_6666_0F0F_F0F0, 0,
                      64'hFEDC_BA98_7654_3210, 1, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
